// File: rtl/lcd_scan.sv
`timescale 1ns/1ps
// lcd_scan: scans the screen VRAM and drives a 640x480@60 raster carrying the
// 640x64 Z88 screen, each Z88 line shown on 4 consecutive raster lines.
// Ports:
//   mck      master clock
//   rin      synchronous reset, active-high
//   pix_ce   pixel clock enable (one mck pulse per pixel)
//   lcdon    LCD enable; low blanks pixels, syncs keep running
//   vram_a   VRAM read address {sline[5:0], nib[7:0]}
//   vram_re  VRAM read strobe, one mck wide
//   vram_di  VRAM read data, valid on the mck edge after vram_re (bit3 = leftmost)
//   hs_n     horizontal sync, active-low
//   vs_n     vertical sync, active-low
//   de       display enable (visible 640x480)
//   pix      pixel on (1 = dark dot)
//   fstart   one-mck pulse at the start of each frame
module lcd_scan (
  input  logic        mck,
  input  logic        rin,
  input  logic        pix_ce,
  input  logic        lcdon,
  output logic [13:0] vram_a,
  output logic        vram_re,
  input  logic [3:0]  vram_di,
  output logic        hs_n,
  output logic        vs_n,
  output logic        de,
  output logic        pix,
  output logic        fstart
);

  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned H_VIS     = 640;
  localparam int unsigned V_VIS     = 480;
  localparam int unsigned HS_START  = 656;
  localparam int unsigned HS_END    = 751;
  localparam int unsigned VS_START  = 490;
  localparam int unsigned VS_END    = 491;
  localparam int unsigned WIN_TOP   = 112;
  localparam int unsigned WIN_BOT   = 367;
  localparam int unsigned H_NIB_END = 634;
  localparam int unsigned H_ROW_FCH = 798;

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [3:0]  cur;
  logic [3:0]  nxt;
  logic        nxt_vld;

  logic        h_last;
  logic        v_last;
  logic [9:0]  vnext;
  logic        in_row;
  logic        in_next_row;
  logic        in_win;
  logic        visible;
  logic        hs_act;
  logic        vs_act;
  logic [5:0]  sline_cur;
  logic [5:0]  sline_next;
  logic        fetch_nib;
  logic        fetch_row;
  logic [13:0] fetch_addr;

  // Raster decode and prefetch decision for the current counter position
  always_comb begin
    h_last      = (hcnt == 10'(H_TOTAL - 1));
    v_last      = (vcnt == 10'(V_TOTAL - 1));
    vnext       = v_last ? 10'd0 : vcnt + 10'd1;
    in_row      = (vcnt >= 10'(WIN_TOP)) && (vcnt <= 10'(WIN_BOT));
    in_next_row = (vnext >= 10'(WIN_TOP)) && (vnext <= 10'(WIN_BOT));
    in_win      = in_row && (hcnt < 10'(H_VIS));
    visible     = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
    hs_act      = (hcnt >= 10'(HS_START)) && (hcnt <= 10'(HS_END));
    vs_act      = (vcnt >= 10'(VS_START)) && (vcnt <= 10'(VS_END));
    sline_cur   = 6'((vcnt - 10'(WIN_TOP)) >> 2);
    sline_next  = 6'((vnext - 10'(WIN_TOP)) >> 2);
    // Nibble n+1 is requested two pixels before nibble n finishes
    fetch_nib   = lcdon && in_row && (hcnt[1:0] == 2'd2) && (hcnt <= 10'(H_NIB_END));
    // First nibble of the next raster line is requested at the end of this one
    fetch_row   = lcdon && in_next_row && (hcnt == 10'(H_ROW_FCH));
    fetch_addr  = fetch_row ? {sline_next, 8'd0} : {sline_cur, hcnt[9:2] + 8'd1};
  end

  // Counters, prefetch, nibble shift path and registered video outputs
  always_ff @(posedge mck) begin
    if (rin) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hs_n    <= 1'b1;
      vs_n    <= 1'b1;
      de      <= 1'b0;
      pix     <= 1'b0;
      fstart  <= 1'b0;
      vram_re <= 1'b0;
      vram_a  <= '0;
      cur     <= '0;
      nxt     <= '0;
      nxt_vld <= 1'b0;
    end else begin
      vram_re <= 1'b0;
      fstart  <= 1'b0;
      if (vram_re) begin
        nxt     <= vram_di;
        nxt_vld <= 1'b1;
      end
      if (pix_ce) begin
        de     <= visible;
        hs_n   <= ~hs_act;
        vs_n   <= ~vs_act;
        fstart <= h_last && v_last;
        if (fetch_nib || fetch_row) begin
          vram_re <= 1'b1;
          vram_a  <= fetch_addr;
        end
        // lcdon low flushes everything so no stale nibble survives a rise
        if (!lcdon) begin
          cur     <= '0;
          nxt_vld <= 1'b0;
          pix     <= 1'b0;
        end else if (!in_win) begin
          pix <= 1'b0;
        end else if (hcnt[1:0] == 2'd0) begin
          nxt_vld <= 1'b0;
          if (nxt_vld) begin
            cur <= nxt;
            pix <= nxt[3];
          end else begin
            cur <= '0;
            pix <= 1'b0;
          end
        end else begin
          pix <= cur[~hcnt[1:0]];
        end
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_scan.sv
`timescale 1ns/1ps
// tb_lcd_scan: randomized self-checking bench for lcd_scan against a raster
// model computed from absolute pixel index arithmetic.
module tb_lcd_scan;

  logic        mck = 1'b0;
  logic        rin;
  logic        pix_ce;
  logic        lcdon;
  logic [13:0] vram_a;
  logic        vram_re;
  logic [3:0]  vram_di;
  logic        hs_n;
  logic        vs_n;
  logic        de;
  logic        pix;
  logic        fstart;

  logic [3:0]  mem [0:16383];
  logic [9:0]  jh;
  logic [9:0]  jv;
  logic [3:0]  held;
  logic        pat_on;
  logic [7:0]  pat;

  int n_checks = 0;
  int n_fail   = 0;
  int t;
  int last_off;
  int fs_count;
  int hs_count;
  int vs_count;

  lcd_scan dut (
    .mck     (mck),
    .rin     (rin),
    .pix_ce  (pix_ce),
    .lcdon   (lcdon),
    .vram_a  (vram_a),
    .vram_re (vram_re),
    .vram_di (vram_di),
    .hs_n    (hs_n),
    .vs_n    (vs_n),
    .de      (de),
    .pix     (pix),
    .fstart  (fstart)
  );

  assign vram_di = mem[vram_a];

  always #5 mck = ~mck;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pixel index %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic in_row(input int v);
    return (v >= 112) && (v <= 367);
  endfunction

  // One pixel: idle mck cycles precede nothing; pix_ce first, then gap-1 idle cycles
  task automatic pix_step(input int gap, input logic lc);
    int h, v, vn, k, e_addr;
    logic e_pix, e_re;
    logic [5:0] e_out;
    h  = t % 800;
    v  = (t / 800) % 525;
    vn = (v == 524) ? 0 : v + 1;
    k  = h % 4;
    lcdon  = lc;
    pix_ce = 1'b1;
    if (!lc) last_off = t;
    @(posedge mck); #1;
    pix_ce = 1'b0;
    // A pixel is shown only if lcdon held from its nibble fetch up to itself
    e_pix = 1'b0;
    if (h < 640 && in_row(v) && last_off < t - 2 - k)
      e_pix = mem[((v - 112) / 4) * 256 + h / 4][3 - k];
    e_re   = lc && ((k == 2 && h <= 634 && in_row(v)) || (h == 798 && in_row(vn)));
    e_addr = (h == 798) ? ((vn - 112) / 4) * 256 : ((v - 112) / 4) * 256 + h / 4 + 1;
    e_out  = {(h < 640 && v < 480), !(h >= 656 && h <= 751), !(v >= 490 && v <= 491),
              e_pix, (h == 799 && v == 524), e_re};
    check("outs", 32'({de, hs_n, vs_n, pix, fstart, vram_re}), 32'(e_out));
    if (e_re) check("vram_a", 32'(vram_a), 32'(e_addr));
    if (pat_on && v >= 112 && v <= 115 && h < 8) check("pattern", 32'(pix), 32'(pat[7 - h]));
    if (lc && h == 798 && v == 111) check("fetch_111", 32'({vram_re, vram_a}), 32'({1'b1, 14'h0000}));
    if (lc && h == 634 && v == 113) check("fetch_113", 32'({vram_re, vram_a}), 32'({1'b1, 6'd0, 8'd159}));
    if (h == 798 && v == 367) check("fetch_367", 32'(vram_re), 32'(0));
    if (fstart) fs_count++;
    if (!hs_n) hs_count++;
    if (!vs_n) vs_count++;
    held = e_out[5:2];
    t++;
    for (int i = 1; i < gap; i++) begin
      @(posedge mck); #1;
      check("idle", 32'({de, hs_n, vs_n, pix, fstart, vram_re}), 32'({held, 2'b00}));
    end
  endtask

  // Reset, then optionally place the raster counters at (h0, v0)
  task automatic do_reset(input int h0, input int v0);
    rin    = 1'b1;
    pix_ce = 1'b0;
    repeat (3) @(posedge mck);
    #1;
    check("rst_outs", 32'({de, hs_n, vs_n, pix, fstart, vram_re}), 32'(6'b011000));
    check("rst_addr", 32'(vram_a), 32'(0));
    rin = 1'b0;
    repeat (2) begin
      @(posedge mck); #1;
      check("post_rst", 32'({de, hs_n, vs_n, pix, fstart, vram_re}), 32'(6'b011000));
    end
    if (h0 != 0 || v0 != 0) begin
      jh = 10'(h0);
      jv = 10'(v0);
      force dut.hcnt = jh;
      force dut.vcnt = jv;
      @(posedge mck); #1;
      release dut.hcnt;
      release dut.vcnt;
    end
    t        = v0 * 800 + h0;
    last_off = t - 1;
    fs_count = 0;
    hs_count = 0;
    vs_count = 0;
  endtask

  task automatic run_to(input int t_end, input int gmin, input int gmax);
    while (t < t_end) pix_step(int'($urandom_range(gmax, gmin)), 1'b1);
  endtask

  initial begin
    int v, h;
    logic lc_r;
    rin    = 1'b1;
    pix_ce = 1'b0;
    lcdon  = 1'b1;
    pat_on = 1'b0;
    pat    = 8'b1010_0011;
    t      = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom);
    mem[0] = 4'hA;
    mem[1] = 4'h3;
    for (int i = 256; i < 512; i++) mem[i] = 4'h0;

    // Reset and first line with fixed 4-mck pixel spacing
    do_reset(0, 0);
    run_to(1000, 4, 4);
    check("hs_low_count", 32'(hs_count), 32'(96));

    // Vertical sync region
    do_reset(700, 488);
    run_to(492 * 800 + 100, 2, 3);
    check("vs_low_count", 32'(vs_count), 32'(1600));

    // Top of the screen window with known pattern, fixed spacing
    pat_on = 1'b1;
    do_reset(700, 111);
    run_to(117 * 800 + 20, 4, 4);

    // Irregular spacing over the same region
    do_reset(700, 111);
    run_to(114 * 800 + 40, 2, 7);
    pat_on = 1'b0;

    // Bottom of the screen window
    do_reset(700, 366);
    run_to(369 * 800 + 100, 2, 3);

    // lcdon drop, mid-line rise, then random toggling
    do_reset(700, 199);
    lc_r = 1'b1;
    while (t < 204 * 800) begin
      h = t % 800;
      v = t / 800;
      if (v == 203) begin
        if ($urandom_range(39, 0) == 0) lc_r = ~lc_r;
      end else begin
        lc_r = !((v == 200 && h >= 300) || v == 201 || (v == 202 && h < 100));
      end
      pix_step(int'($urandom_range(3, 2)), lc_r);
    end

    // Frame wrap and frame start pulse
    do_reset(780, 524);
    run_to(420000 + 40, 2, 3);
    check("fstart_count", 32'(fs_count), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
